// File: rtl/fpu_cmd_sched.sv
// fpu_cmd_sched: bus-written FPU command FIFO issued one at a time over a start/done handshake.
// Optional WAIT-state watchdog is built when FPU_SCHED_TIMEOUT_EN is defined.
module fpu_cmd_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_strobe,
   input  logic        bus_we,
   input  logic        bus_match,
   input  logic [1:0]  bus_word,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ack,
   output logic        fpu_start,
   output logic [3:0]  fpu_op,
   output logic [4:0]  fpu_rd,
   output logic [4:0]  fpu_rs1,
   output logic [4:0]  fpu_rs2,
   input  logic        fpu_done,
   input  logic [4:0]  fpu_exc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;

   logic [18:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   logic          start_r;
   logic          start_nxt_s;
   logic          load_s;
   logic [3:0]    op_r;
   logic [4:0]    rd_r;
   logic [4:0]    rs1_r;
   logic [4:0]    rs2_r;

   logic [4:0]    flags_r;
   logic [15:0]   done_cnt_r;
   logic          overflow_r;
   logic          timeout_r;

   logic          wr_sel_s;
   logic          push_req_s;
   logic          status_wr_s;
   logic          flags_wr_s;
   logic          empty_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic          done_s;
   logic          tmo_hit_s;
   logic          busy_s;
   logic [31:0]   status_s;
   logic          unused_ok_s;

   assign wr_sel_s    = bus_strobe & bus_we & bus_match;
   assign push_req_s  = wr_sel_s & (bus_word == 2'd0);
   assign status_wr_s = wr_sel_s & (bus_word == 2'd1);
   assign flags_wr_s  = wr_sel_s & (bus_word == 2'd2);

   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == DEPTH_C);
   assign push_s  = push_req_s & ~full_s;
   assign pop_s   = (state_r == S_ISSUE);
   assign done_s  = (state_r == S_WAIT) & fpu_done;
   assign busy_s  = (state_r != S_IDLE) | ~empty_s;

   assign bus_ack = bus_strobe;

`ifdef FPU_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1) + 1;
   logic [TW-1:0] tmo_cnt_r;

   // Watchdog: zeroed while issuing so it starts from zero on WAIT entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (state_r == S_ISSUE) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (state_r == S_WAIT) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // A done on the expiry cycle wins over the watchdog
   assign tmo_hit_s   = (state_r == S_WAIT) & ~fpu_done & (tmo_cnt_r == TW'(TIMEOUT - 1));
   assign unused_ok_s = ^bus_wdata[31:19];
`else
   assign tmo_hit_s   = 1'b0;
   assign unused_ok_s = ^{bus_wdata[31:19], 32'(TIMEOUT)};
`endif

   // Command storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 19'd0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= bus_wdata[18:0];
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers and occupancy; a push into a full FIFO is dropped even when popping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (!empty_s) begin
               state_nxt_s = S_ISSUE;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ISSUE: state_nxt_s = S_WAIT;
         S_WAIT: begin
            if (done_s || tmo_hit_s) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // FSM outputs: head load and start request, registered below
   always_comb begin
      load_s      = 1'b0;
      start_nxt_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!empty_s) begin
               load_s      = 1'b1;
               start_nxt_s = 1'b1;
            end else begin
               load_s      = 1'b0;
               start_nxt_s = 1'b0;
            end
         end
         default: begin
            load_s      = 1'b0;
            start_nxt_s = 1'b0;
         end
      endcase
   end

   // Issue pulse and command field registers; fields hold until the next load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_r <= 1'b0;
         op_r    <= 4'd0;
         rd_r    <= 5'd0;
         rs1_r   <= 5'd0;
         rs2_r   <= 5'd0;
      end else begin
         start_r <= start_nxt_s;
         if (load_s) begin
            {rs2_r, rs1_r, rd_r, op_r} <= mem_r[rd_ptr_r];
         end else begin
            {rs2_r, rs1_r, rd_r, op_r} <= {rs2_r, rs1_r, rd_r, op_r};
         end
      end
   end

   assign fpu_start = start_r;
   assign fpu_op    = op_r;
   assign fpu_rd    = rd_r;
   assign fpu_rs1   = rs1_r;
   assign fpu_rs2   = rs2_r;

   // Sticky status and completion count; a set beats a same-cycle write-1-to-clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r    <= 5'd0;
         done_cnt_r <= 16'd0;
         overflow_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         flags_r    <= (flags_r & ~(flags_wr_s ? bus_wdata[4:0] : 5'd0))
                       | (done_s ? fpu_exc : 5'd0);
         overflow_r <= (overflow_r & ~(status_wr_s & bus_wdata[3])) | (push_req_s & full_s);
         timeout_r  <= (timeout_r & ~(status_wr_s & bus_wdata[4])) | tmo_hit_s;
         if (done_s) begin
            done_cnt_r <= done_cnt_r + 16'd1;
         end else begin
            done_cnt_r <= done_cnt_r;
         end
      end
   end

   assign status_s = {done_cnt_r, 3'd0, 5'(count_r), 3'd0,
                      timeout_r, overflow_r, empty_s, full_s, busy_s};

   // Zero-wait-state read mux
   always_comb begin
      bus_rdata = 32'd0;
      case (bus_word)
         2'd1:    bus_rdata = status_s;
         2'd2:    bus_rdata = {27'd0, flags_r};
         default: bus_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_fpu_cmd_sched.sv
// Self-checking bench for fpu_cmd_sched: vector table plus a start-pulse scoreboard
// and hand-written sequences for overflow, back-to-back issue, watchdog and reset.
module tb_fpu_cmd_sched;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_strobe;
   logic        bus_we;
   logic        bus_match;
   logic [1:0]  bus_word;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        fpu_start;
   logic [3:0]  fpu_op;
   logic [4:0]  fpu_rd;
   logic [4:0]  fpu_rs1;
   logic [4:0]  fpu_rs2;
   logic        fpu_done;
   logic [4:0]  fpu_exc;

   fpu_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .bus_strobe(bus_strobe), .bus_we(bus_we), .bus_match(bus_match),
      .bus_word(bus_word), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rd(fpu_rd), .fpu_rs1(fpu_rs1),
      .fpu_rs2(fpu_rs2), .fpu_done(fpu_done), .fpu_exc(fpu_exc)
   );

   typedef struct {
      logic [31:0] wdata;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  exc;
   } vec_t;

   typedef struct {
      logic [3:0] op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] exc;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          start_cnt = 0;
   int          start_q[$];
   exp_t        sb_q[$];
   logic [4:0]  cur_exc = 5'd0;
   bit          auto_done = 1'b0;
   bit          pend = 1'b0;
   int          kick_req = 0;
   int          kick_srv = 0;

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_status(input logic busy, input logic full, input logic empty,
                                             input logic ovf, input logic tmo,
                                             input logic [4:0] cnt, input logic [15:0] dc);
      return {dc, 3'd0, cnt, 3'd0, tmo, ovf, empty, full, busy};
   endfunction

   // Scoreboard: every start pulse must match the oldest accepted command
   initial forever begin
      @(negedge clk);
      if (rst_n && fpu_start) begin
         start_cnt++;
         start_q.push_back(cyc);
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_unexpected: got start with op=%0d rd=%0d, expected no start", fpu_op, fpu_rd);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check32("issue_fields", {13'd0, fpu_rs2, fpu_rs1, fpu_rd, fpu_op},
                    {13'd0, e.rs2, e.rs1, e.rd, e.op});
            cur_exc = e.exc;
         end
      end
   end

   // FPU model: auto mode answers one cycle after WAIT entry; kicks answer on demand
   initial begin
      fpu_done = 1'b0;
      fpu_exc  = 5'd0;
      forever begin
         @(posedge clk);
         #1;
         fpu_done = 1'b0;
         fpu_exc  = 5'd0;
         if (pend) begin
            fpu_done = 1'b1;
            fpu_exc  = cur_exc;
            pend     = 1'b0;
         end else if (kick_srv != kick_req) begin
            fpu_done = 1'b1;
            fpu_exc  = cur_exc;
            kick_srv++;
         end
         if (auto_done && fpu_start) pend = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "bench timeout");
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] w, input logic [31:0] d, input logic m, output int acc);
      bus_strobe = 1'b1;
      bus_we     = 1'b1;
      bus_match  = m;
      bus_word   = w;
      bus_wdata  = d;
      @(posedge clk);
      #1;
      acc        = cyc;
      bus_strobe = 1'b0;
      bus_we     = 1'b0;
      bus_match  = 1'b0;
      bus_wdata  = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] w, output logic [31:0] d);
      bus_word = w;
      #1;
      d = bus_rdata;
   endtask

   task automatic push_cmd(input logic [31:0] wdata, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] exc,
                           output int acc);
      exp_t e;
      e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.exc = exc;
      sb_q.push_back(e);
      bus_write(2'd0, wdata, 1'b1, acc);
   endtask

   task automatic wait_idle(input int max_cyc);
      logic [31:0] s;
      bus_read(2'd1, s);
      for (int k = 0; k < max_cyc && s[0]; k++) begin
         cycles(1);
         bus_read(2'd1, s);
      end
      check32("wait_idle_busy", {31'd0, s[0]}, 32'd0);
   endtask

   vec_t        vecs[6];
   logic [31:0] rd_v;
   logic [15:0] exp_dc;
   int          wr;
   int          wr0;
   int          snap;

   initial begin
      vecs[0] = '{32'h0000_4A31, 4'd1,  5'd3,  5'd5,  5'd1,  5'b00100};
      vecs[1] = '{32'hFFFF_FFFF, 4'hF,  5'd31, 5'd31, 5'd31, 5'b11111};
      vecs[2] = '{32'h0000_0000, 4'd0,  5'd0,  5'd0,  5'd0,  5'b00000};
      vecs[3] = '{32'hFFF8_0000, 4'd0,  5'd0,  5'd0,  5'd0,  5'b10001};
      vecs[4] = '{32'h0007_FFFF, 4'hF,  5'd31, 5'd31, 5'd31, 5'b01010};
      vecs[5] = '{32'h8005_8ECA, 4'hA,  5'd12, 5'd7,  5'd22, 5'b00001};
      exp_dc = 16'd0;

      rst_n      = 1'b0;
      bus_strobe = 1'b0;
      bus_we     = 1'b0;
      bus_match  = 1'b0;
      bus_word   = 2'd0;
      bus_wdata  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      bus_read(2'd1, rd_v);
      check32("reset_status", rd_v, 32'h0000_0004);
      check32("reset_fpu_outs", {12'd0, fpu_start, fpu_rs2, fpu_rs1, fpu_rd, fpu_op}, 32'd0);
      rst_n = 1'b1;
      cycles(20);
      check32("idle_no_start", 32'(start_cnt), 32'd0);
      bus_read(2'd1, rd_v);
      check32("idle_status", rd_v, 32'h0000_0004);
      bus_read(2'd2, rd_v);
      check32("idle_flags", rd_v, 32'd0);
      bus_read(2'd0, rd_v);
      check32("cmd_reads_zero", rd_v, 32'd0);
      bus_read(2'd3, rd_v);
      check32("rsvd_reads_zero", rd_v, 32'd0);
      bus_strobe = 1'b1;
      #1;
      check32("bus_ack_hi", {31'd0, bus_ack}, 32'd1);
      bus_strobe = 1'b0;
      #1;
      check32("bus_ack_lo", {31'd0, bus_ack}, 32'd0);
      bus_write(2'd0, 32'h0000_4A31, 1'b0, wr);
      cycles(5);
      check32("nomatch_no_start", 32'(start_cnt), 32'd0);
      bus_read(2'd1, rd_v);
      check32("nomatch_status", rd_v, 32'h0000_0004);

      // Table: one command at a time, auto-completed
      auto_done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         start_q.delete();
         push_cmd(vecs[i].wdata, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].exc, wr);
         wait_idle(50);
         check32("vec_issue_count", 32'(start_q.size()), 32'd1);
         check32("vec_issue_latency", (start_q.size() == 1) ? 32'(start_q[0]) : 32'hFFFF_FFFF, 32'(wr + 1));
         exp_dc = exp_dc + 16'd1;
         bus_read(2'd2, rd_v);
         check32("vec_flags", rd_v, {27'd0, vecs[i].exc});
         bus_read(2'd1, rd_v);
         check32("vec_status", rd_v, mk_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, exp_dc));
         bus_write(2'd2, 32'h0000_001F, 1'b1, wr);
         bus_read(2'd2, rd_v);
         check32("vec_flags_clr", rd_v, 32'd0);
      end

      // FLAGS: a set coinciding with its clear survives
      push_cmd({13'd0, 5'd2, 5'd4, 5'd6, 4'd3}, 4'd3, 5'd6, 5'd4, 5'd2, 5'b00011, wr);
      wait_idle(50);
      bus_read(2'd2, rd_v);
      check32("flags_accum", rd_v, 32'h0000_0003);
      push_cmd({13'd0, 5'd9, 5'd8, 5'd7, 4'd5}, 4'd5, 5'd7, 5'd8, 5'd9, 5'b00010, wr);
      cycles(2);
      bus_write(2'd2, 32'h0000_001F, 1'b1, wr0);
      wait_idle(50);
      exp_dc = exp_dc + 16'd2;
      bus_read(2'd2, rd_v);
      check32("flags_set_wins", rd_v, 32'h0000_0002);

      // Overflow: one issued plus DEPTH queued, then a dropped push
      auto_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_cmd({13'd0, 5'(i + 10), 5'(i + 20), 5'(i + 1), 4'(i + 8)},
                  4'(i + 8), 5'(i + 1), 5'(i + 20), 5'(i + 10), 5'd0, wr);
      end
      bus_read(2'd1, rd_v);
      check32("ovf_full", rd_v, mk_status(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, exp_dc));
      bus_write(2'd0, {13'd0, 5'd30, 5'd30, 5'd30, 4'd7}, 1'b1, wr);
      bus_read(2'd1, rd_v);
      check32("ovf_set", rd_v, mk_status(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, exp_dc));
      bus_write(2'd1, 32'h0000_0008, 1'b1, wr);
      bus_read(2'd1, rd_v);
      check32("ovf_w1c", rd_v, mk_status(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, exp_dc));
      auto_done = 1'b1;
      kick_req++;
      wait_idle(100);
      exp_dc = exp_dc + 16'd5;
      bus_read(2'd1, rd_v);
      check32("ovf_drained", rd_v, mk_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, exp_dc));
      check32("ovf_sb_empty", 32'(sb_q.size()), 32'd0);

      // Back-to-back: three queued, done one cycle after each WAIT entry
      start_q.delete();
      for (int i = 0; i < 3; i++) begin
         push_cmd({13'd0, 5'(i), 5'(i + 3), 5'(i + 6), 4'(i + 1)},
                  4'(i + 1), 5'(i + 6), 5'(i + 3), 5'(i), 5'd0, wr);
      end
      wait_idle(100);
      exp_dc = exp_dc + 16'd3;
      check32("b2b_count", 32'(start_q.size()), 32'd3);
      check32("b2b_gap1", (start_q.size() == 3) ? 32'(start_q[1] - start_q[0]) : 32'hFFFF_FFFF, 32'd3);
      check32("b2b_gap2", (start_q.size() == 3) ? 32'(start_q[2] - start_q[1]) : 32'hFFFF_FFFF, 32'd3);
      bus_read(2'd1, rd_v);
      check32("b2b_status", rd_v, mk_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, exp_dc));

`ifdef FPU_SCHED_TIMEOUT_EN
      // Watchdog: first command never completes, second issues after expiry
      auto_done = 1'b0;
      start_q.delete();
      push_cmd({13'd0, 5'd1, 5'd2, 5'd3, 4'd4}, 4'd4, 5'd3, 5'd2, 5'd1, 5'd0, wr);
      push_cmd({13'd0, 5'd5, 5'd6, 5'd7, 4'd8}, 4'd8, 5'd7, 5'd6, 5'd5, 5'd0, wr);
      cycles(14);
      check32("tmo_issue_count", 32'(start_q.size()), 32'd2);
      check32("tmo_gap", (start_q.size() == 2) ? 32'(start_q[1] - start_q[0]) : 32'hFFFF_FFFF, 32'd10);
      bus_read(2'd1, rd_v);
      check32("tmo_status", rd_v, mk_status(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, exp_dc));
      kick_req++;
      wait_idle(50);
      exp_dc = exp_dc + 16'd1;
      bus_read(2'd1, rd_v);
      check32("tmo_after_done", rd_v, mk_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, exp_dc));
      bus_write(2'd1, 32'h0000_0010, 1'b1, wr);
      bus_read(2'd1, rd_v);
      check32("tmo_w1c", rd_v, mk_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, exp_dc));
`else
      // No watchdog: WAIT holds until done arrives
      auto_done = 1'b0;
      push_cmd({13'd0, 5'd1, 5'd2, 5'd3, 4'd4}, 4'd4, 5'd3, 5'd2, 5'd1, 5'd0, wr);
      cycles(20);
      bus_read(2'd1, rd_v);
      check32("wait_hold_status", rd_v, mk_status(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, exp_dc));
      kick_req++;
      wait_idle(50);
      exp_dc = exp_dc + 16'd1;
      bus_read(2'd1, rd_v);
      check32("wait_done_status", rd_v, mk_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, exp_dc));
`endif

      // Reset while in WAIT with two queued
      auto_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_cmd({13'd0, 5'(i + 2), 5'(i + 4), 5'(i + 8), 4'(i + 12)},
                  4'(i + 12), 5'(i + 8), 5'(i + 4), 5'(i + 2), 5'd0, wr);
      end
      cycles(4);
      bus_read(2'd1, rd_v);
      check32("prerst_status", rd_v, mk_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, exp_dc));
      bus_read(2'd2, rd_v);
      check32("prerst_flags", rd_v, 32'h0000_0002);
      rst_n = 1'b0;
      #1;
      bus_read(2'd1, rd_v);
      check32("rst_status", rd_v, 32'h0000_0004);
      check32("rst_fpu_outs", {12'd0, fpu_start, fpu_rs2, fpu_rs1, fpu_rd, fpu_op}, 32'd0);
      sb_q.delete();
      snap = start_cnt;
      cycles(2);
      rst_n = 1'b1;
      cycles(20);
      check32("postrst_no_start", 32'(start_cnt), 32'(snap));
      bus_read(2'd1, rd_v);
      check32("postrst_status", rd_v, 32'h0000_0004);
      bus_read(2'd2, rd_v);
      check32("postrst_flags", rd_v, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
